// File: rtl/spi_a2d_model_mc.sv
// Multi-channel SPI A2D serf model for Segway-level benches.
// Returns the channel requested by the previous completed frame on MISO.
// Optional dither is enabled by defining A2D_NOISE_EN.
module spi_a2d_model_mc #(
  parameter int NUM_CH  = 8,
  parameter int DATA_W  = 12,
  parameter int FRAME_W = 16,
  parameter int CH_LSB  = 11
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       SS_n,
  input  logic                       SCLK,
  input  logic                       MOSI,
  output logic                       MISO,
  input  logic [NUM_CH*DATA_W-1:0]   ch_data,
  output logic                       frame_done,
  output logic                       frame_abrt,
  output logic                       ch_err,
  output logic [3:0]                 last_ch
);

  localparam int CNT_W = $clog2(FRAME_W) + 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t               state_q, state_d;
  logic [FRAME_W-1:0]   tx_q, tx_d;
  logic [FRAME_W-1:0]   rx_q, rx_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [3:0]           sel_q, sel_d;
  logic [3:0]           lastCh_q, lastCh_d;
  logic                 chErr_q, chErr_d;
  logic                 done_q, done_d;
  logic                 abrt_q, abrt_d;

  logic [2:0]           ssSync_q;
  logic [2:0]           sclkSync_q;
  logic [1:0]           mosiSync_q;
  logic                 ssFall, ssRise, sclkRise, sclkFall, mosiS;

  logic [DATA_W-1:0]    chVal;
  logic [DATA_W-1:0]    snapVal;
  logic [FRAME_W-1:0]   rxNext;
  logic [3:0]           idx;

  // Two-flop synchronisers plus one extra stage on SS_n/SCLK for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ssSync_q   <= 3'b111;
      sclkSync_q <= 3'b111;
      mosiSync_q <= 2'b00;
    end else begin
      ssSync_q   <= {ssSync_q[1:0], SS_n};
      sclkSync_q <= {sclkSync_q[1:0], SCLK};
      mosiSync_q <= {mosiSync_q[0], MOSI};
    end
  end

  assign ssFall   =  ssSync_q[2]   & ~ssSync_q[1];
  assign ssRise   = ~ssSync_q[2]   &  ssSync_q[1];
  assign sclkFall =  sclkSync_q[2] & ~sclkSync_q[1];
  assign sclkRise = ~sclkSync_q[2] &  sclkSync_q[1];
  assign mosiS    =  mosiSync_q[1];

  // Select the value of the currently latched channel from the flattened bus
  always_comb begin
    chVal = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (sel_q == 4'(k)) chVal = ch_data[k*DATA_W +: DATA_W];
    end
  end

`ifdef A2D_NOISE_EN
  logic [15:0] lfsr_q, lfsr_d;
  logic        lfsrFb;

  assign lfsrFb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];

  // Dither the snapshot by -1/0/+1 with saturation; the LFSR advances once per frame
  always_comb begin
    snapVal = chVal;
    lfsr_d  = lfsr_q;
    if (state_q == IDLE && ssFall) lfsr_d = {lfsr_q[14:0], lfsrFb};
    case (lfsr_q[1:0])
      2'b01:   if (chVal != '1) snapVal = chVal + DATA_W'(1);
      2'b10:   if (chVal != '0) snapVal = chVal - DATA_W'(1);
      default: snapVal = chVal;
    endcase
  end

  // LFSR register, seeded to a fixed non-zero value at reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr_q <= 16'hACE1;
    else        lfsr_q <= lfsr_d;
  end
`else
  assign snapVal = chVal;
`endif

  // Next-state and datapath updates for the frame FSM
  always_comb begin
    state_d  = state_q;
    tx_d     = tx_q;
    rx_d     = rx_q;
    cnt_d    = cnt_q;
    sel_d    = sel_q;
    lastCh_d = lastCh_q;
    chErr_d  = chErr_q;
    done_d   = 1'b0;
    abrt_d   = 1'b0;
    rxNext   = {rx_q[FRAME_W-2:0], mosiS};
    idx      = rxNext[CH_LSB+3:CH_LSB];
    case (state_q)
      IDLE: begin
        if (ssFall) begin
          state_d = SHIFT;
          tx_d    = FRAME_W'(snapVal);
          rx_d    = '0;
          cnt_d   = '0;
        end
      end
      SHIFT: begin
        if (ssRise) begin
          state_d = IDLE;
          abrt_d  = 1'b1;
          rx_d    = '0;
        end else begin
          if (sclkFall) tx_d = {tx_q[FRAME_W-2:0], 1'b0};
          if (sclkRise) begin
            rx_d  = rxNext;
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(FRAME_W - 1)) begin
              state_d  = DONE;
              done_d   = 1'b1;
              lastCh_d = idx;
              if ({1'b0, idx} < 5'(NUM_CH)) begin
                sel_d = idx;
              end else begin
                sel_d   = '0;
                chErr_d = 1'b1;
              end
            end
          end
        end
      end
      DONE: begin
        if (ssRise) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      tx_q     <= '0;
      rx_q     <= '0;
      cnt_q    <= '0;
      sel_q    <= '0;
      lastCh_q <= '0;
      chErr_q  <= 1'b0;
      done_q   <= 1'b0;
      abrt_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      tx_q     <= tx_d;
      rx_q     <= rx_d;
      cnt_q    <= cnt_d;
      sel_q    <= sel_d;
      lastCh_q <= lastCh_d;
      chErr_q  <= chErr_d;
      done_q   <= done_d;
      abrt_q   <= abrt_d;
    end
  end

  assign MISO       = (state_q == SHIFT) ? tx_q[FRAME_W-1] : 1'b0;
  assign frame_done = done_q;
  assign frame_abrt = abrt_q;
  assign ch_err     = chErr_q;
  assign last_ch    = lastCh_q;

endmodule

// File: tb/tb_spi_a2d_model_mc.sv
// Directed bench for spi_a2d_model_mc (8 channels, 12-bit data, SCLK = clk/32).
module tb_spi_a2d_model_mc;

  logic        clk;
  logic        rst_n;
  logic        SS_n;
  logic        SCLK;
  logic        MOSI;
  logic        MISO;
  logic [95:0] chData;
  logic        frame_done;
  logic        frame_abrt;
  logic        ch_err;
  logic [3:0]  last_ch;

  int          checks;
  int          errors;
  int          doneCnt;
  int          abrtCnt;
  int          d0;
  int          a0;
  logic [15:0] resp;

  spi_a2d_model_mc #(
    .NUM_CH(8), .DATA_W(12), .FRAME_W(16), .CH_LSB(11)
  ) dut (
    .clk(clk), .rst_n(rst_n), .SS_n(SS_n), .SCLK(SCLK), .MOSI(MOSI), .MISO(MISO),
    .ch_data(chData), .frame_done(frame_done), .frame_abrt(frame_abrt),
    .ch_err(ch_err), .last_ch(last_ch)
  );

  // Free-running system clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count every clock the pulse outputs are high, so a stretched pulse shows up as extra counts
  always @(posedge clk) begin
    if (frame_done === 1'b1) doneCnt++;
    if (frame_abrt === 1'b1) abrtCnt++;
  end

  task automatic waitClk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  // One SPI frame; mode 0 = full frame, 1 = abort after stopAt rises, 2 = reset after stopAt rises.
  // MISO is sampled just before each SCLK fall; MOSI changes on the fall.
  task automatic applyStimulus(input logic [15:0] cmd, input int mode, input int stopAt,
                               input int chgAt, input int chgCh, input logic [11:0] chgVal,
                               output logic [15:0] rsp);
    rsp  = '0;
    SS_n = 1'b0;
    waitClk(16);
    for (int i = 0; i < 16; i++) begin
      rsp[15-i] = MISO;
      SCLK = 1'b0;
      MOSI = cmd[15-i];
      waitClk(16);
      SCLK = 1'b1;
      waitClk(16);
      if (chgAt == i + 1) chData[chgCh*12 +: 12] = chgVal;
      if (mode != 0 && stopAt == i + 1) break;
    end
    if (mode == 0) begin
      checkOutput("miso_in_done", {31'b0, MISO}, 32'h0);
      SS_n = 1'b1;
      waitClk(16);
    end else if (mode == 1) begin
      SS_n = 1'b1;
      waitClk(16);
    end else begin
      rst_n = 1'b0;
      waitClk(2);
    end
    MOSI = 1'b0;
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    doneCnt = 0;
    abrtCnt = 0;
    rst_n   = 1'b0;
    SS_n    = 1'b1;
    SCLK    = 1'b1;
    MOSI    = 1'b0;
    chData  = '0;
    chData[0*12 +: 12] = 12'h1A5;
    chData[1*12 +: 12] = 12'h333;
    chData[3*12 +: 12] = 12'hFFF;
    chData[5*12 +: 12] = 12'h2B7;
    waitClk(4);

    checkOutput("rst_miso", {31'b0, MISO}, 32'h0);
    checkOutput("rst_done", {31'b0, frame_done}, 32'h0);
    checkOutput("rst_abrt", {31'b0, frame_abrt}, 32'h0);
    checkOutput("rst_cherr", {31'b0, ch_err}, 32'h0);
    checkOutput("rst_lastch", {28'b0, last_ch}, 32'h0);

    rst_n = 1'b1;
    waitClk(8);
    checkOutput("idle_miso", {31'b0, MISO}, 32'h0);

    // First frame after reset returns channel 0 and requests channel 3
    d0 = doneCnt; a0 = abrtCnt;
    applyStimulus(16'h1800, 0, 0, 0, 0, 12'h0, resp);
    checkOutput("f1_resp", {16'b0, resp}, 32'h01A5);
    checkOutput("f1_lastch", {28'b0, last_ch}, 32'h3);
    checkOutput("f1_done", doneCnt - d0, 1);
    checkOutput("f1_abrt", abrtCnt - a0, 0);

    // Channel 3 response, request channel 0
    applyStimulus(16'h0000, 0, 0, 0, 0, 12'h0, resp);
    checkOutput("f2_resp", {16'b0, resp}, 32'h0FFF);
    checkOutput("f2_lastch", {28'b0, last_ch}, 32'h0);

    // Snapshot isolation: ch3 changes mid-frame but the frame keeps the old value
    applyStimulus(16'h1800, 0, 0, 0, 0, 12'h0, resp);
    checkOutput("f3_resp", {16'b0, resp}, 32'h01A5);
    chData[3*12 +: 12] = 12'h123;
    applyStimulus(16'h1800, 0, 0, 4, 3, 12'h456, resp);
    checkOutput("f4_resp", {16'b0, resp}, 32'h0123);

    // Abort after 9 rising edges
    d0 = doneCnt; a0 = abrtCnt;
    applyStimulus(16'h0000, 1, 9, 0, 0, 12'h0, resp);
    checkOutput("f5_abrt", abrtCnt - a0, 1);
    checkOutput("f5_done", doneCnt - d0, 0);
    checkOutput("f5_lastch", {28'b0, last_ch}, 32'h3);
    applyStimulus(16'h2800, 0, 0, 0, 0, 12'h0, resp);
    checkOutput("f6_resp", {16'b0, resp}, 32'h0456);

    // Illegal channel 12: sticky error, falls back to channel 0
    applyStimulus(16'h6000, 0, 0, 0, 0, 12'h0, resp);
    checkOutput("f7_resp", {16'b0, resp}, 32'h02B7);
    checkOutput("f7_cherr", {31'b0, ch_err}, 32'h1);
    checkOutput("f7_lastch", {28'b0, last_ch}, 32'hC);
    applyStimulus(16'h0800, 0, 0, 0, 0, 12'h0, resp);
    checkOutput("f8_resp", {16'b0, resp}, 32'h01A5);
    checkOutput("f8_cherr", {31'b0, ch_err}, 32'h1);
    applyStimulus(16'h1000, 0, 0, 0, 0, 12'h0, resp);
    checkOutput("f9_resp", {16'b0, resp}, 32'h0333);
    checkOutput("f9_cherr", {31'b0, ch_err}, 32'h1);
    checkOutput("f9_lastch", {28'b0, last_ch}, 32'h2);

    // Reset mid-frame at rising edge 7
    d0 = doneCnt;
    applyStimulus(16'h2800, 2, 7, 0, 0, 12'h0, resp);
    checkOutput("mid_rst_miso", {31'b0, MISO}, 32'h0);
    checkOutput("mid_rst_cherr", {31'b0, ch_err}, 32'h0);
    checkOutput("mid_rst_lastch", {28'b0, last_ch}, 32'h0);
    checkOutput("mid_rst_done", {31'b0, frame_done}, 32'h0);
    checkOutput("mid_rst_abrt", {31'b0, frame_abrt}, 32'h0);
    SS_n = 1'b1;
    SCLK = 1'b1;
    waitClk(4);
    rst_n = 1'b1;
    waitClk(8);
    checkOutput("mid_rst_nodone", doneCnt - d0, 0);
    applyStimulus(16'h2800, 0, 0, 0, 0, 12'h0, resp);
    checkOutput("f11_resp", {16'b0, resp}, 32'h01A5);
    checkOutput("f11_cherr", {31'b0, ch_err}, 32'h0);
    applyStimulus(16'h2800, 0, 0, 0, 0, 12'h0, resp);
    checkOutput("f12_resp", {16'b0, resp}, 32'h02B7);
    checkOutput("f12_lastch", {28'b0, last_ch}, 32'h5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
